// File: rtl/bubble_pkg.sv
// bubble_pkg: shared FSM encoding and default sizing for seq_bubble_sort
package bubble_pkg;
  localparam int DIM_DEF = 4;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/cmp_swap.sv
// cmp_swap: combinational ascending compare-exchange of two unsigned values
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
);
  logic swap;
  assign swap  = b_i < a_i;
  assign min_o = swap ? b_i : a_i;
  assign max_o = swap ? a_i : b_i;
endmodule

// File: rtl/seq_bubble_sort.sv
// seq_bubble_sort: streaming frame sorter using odd-even transposition, one pass per cycle
module seq_bubble_sort
  import bubble_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(DIM);
  localparam int PW = $clog2(DIM + 1);
  localparam int NP = DIM / 2;
  state_e state_q;
  logic [CW-1:0] wr_q, rd_q, rd_d;
  logic [PW-1:0] pass_q;
  logic [WIDTH-1:0] buf_q [DIM];
  logic [WIDTH-1:0] sorted [DIM];
  logic [WIDTH-1:0] lo_a [NP], hi_a [NP], mn [NP], mx [NP];
  logic out_valid_q, out_last_q;
  logic [WIDTH-1:0] out_data_q;
  assign in_ready  = state_q == LOAD;
  assign busy      = state_q != LOAD;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign rd_d      = rd_q + 1'b1;
  // Comparator i serves pair (2i,2i+1) on even passes and (2i+1,2i+2) on odd ones
  for (genvar i = 0; i < NP; i++) begin : g_cs
    localparam int E = 2 * i;
    localparam int O = (2 * i + 2 < DIM) ? 2 * i + 1 : 2 * i;
    assign lo_a[i] = pass_q[0] ? buf_q[O] : buf_q[E];
    assign hi_a[i] = pass_q[0] ? buf_q[O+1] : buf_q[E+1];
    cmp_swap #(.WIDTH(WIDTH)) u_cs (.a_i(lo_a[i]), .b_i(hi_a[i]), .min_o(mn[i]), .max_o(mx[i]));
  end
  for (genvar k = 0; k < DIM; k++) begin : g_nx
    logic [WIDTH-1:0] ev, od;
    if (k % 2 == 0 && k + 1 < DIM) begin : g_e0
      assign ev = mn[k/2];
    end else if (k % 2 == 1) begin : g_e1
      assign ev = mx[k/2];
    end else begin : g_e2
      assign ev = buf_q[k];
    end
    if (k % 2 == 1 && k + 1 < DIM) begin : g_o0
      assign od = mn[k/2];
    end else if (k % 2 == 0 && k > 0) begin : g_o1
      assign od = mx[k/2-1];
    end else begin : g_o2
      assign od = buf_q[k];
    end
    assign sorted[k] = pass_q[0] ? od : ev;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_q        <= '0;
      rd_q        <= '0;
      pass_q      <= '0;
      for (int i = 0; i < DIM; i++) buf_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        LOAD: if (in_valid) begin
          buf_q[wr_q] <= in_data;
          if (wr_q == CW'(DIM - 1)) begin
            state_q <= SORT;
            wr_q    <= '0;
            rd_q    <= '0;
            pass_q  <= '0;
          end else wr_q <= wr_q + 1'b1;
        end
        SORT: begin
          buf_q <= sorted;
          if (pass_q == PW'(DIM - 1)) state_q <= DRAIN;
          else pass_q <= pass_q + 1'b1;
        end
        DRAIN: if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= buf_q[rd_q];
          out_last_q  <= rd_q == CW'(DIM - 1);
        end else if (out_ready) begin
          if (out_last_q) begin
            state_q     <= LOAD;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else begin
            rd_q       <= rd_d;
            out_data_q <= buf_q[rd_d];
            out_last_q <= rd_d == CW'(DIM - 1);
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end
endmodule

// File: doc/seq_bubble_sort.md
SEQ_BUBBLE_SORT -- requirements
Module: seq_bubble_sort

Interface
REQ-001 SHALL have parameter DIM, default 4, number of elements per frame (legal range DIM >= 2).
REQ-002 SHALL have parameter WIDTH, default 8, element width in bits (unsigned).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: unsorted element, streamed one per transfer.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-010 SHALL have port out_data, output, WIDTH bits: sorted element, streamed one per transfer.
REQ-011 SHALL have port out_last, output, 1 bit: marks the final element of a frame.
REQ-012 SHALL have port busy, output, 1 bit: high in SORT and DRAIN.

Function
REQ-013 SHALL implement a three-state FSM: LOAD, SORT and DRAIN.
REQ-014 SHALL count a transfer only when valid and ready are both high in the same cycle.
REQ-015 SHALL assert in_ready only in LOAD, and SHALL write each accepted element to buf[wr], with wr incrementing from 0.
REQ-016 SHALL move LOAD->SORT on the cycle it accepts element DIM-1, and SHALL clear wr, pass and rd at that transition.
REQ-017 SHALL ignore in_valid and in_data outside LOAD.
REQ-018 SHALL perform, in SORT, one odd-even transposition pass per cycle:
  - even pass (pass[0]=0): compare-swap pairs (0,1), (2,3), ...
  - odd pass: compare-swap pairs (1,2), (3,4), ...
  - elements with no partner keep their value.
REQ-019 SHALL order each compare-swap ascending (lower index receives min, higher receives max), unsigned, and SHALL NOT swap equal values.
REQ-020 SHALL run exactly DIM passes (pass 0..DIM-1), then move SORT->DRAIN.
REQ-021 SHALL, in DRAIN, assert out_valid, drive out_data = buf[rd], and drive out_last = (rd == DIM-1).
REQ-022 SHALL hold out_data, out_last and out_valid stable while out_ready is low.
REQ-023 SHALL increment rd on each output transfer, and SHALL move DRAIN->LOAD on the transfer with out_last high.
REQ-024 SHALL have this latency: if the last input is accepted at edge t, out_valid goes high after edge t+DIM+1.
REQ-025 SHALL sustain one output element per cycle when out_ready is held high.
REQ-026 SHALL size counters to clog2(DIM) bits and pass to clog2(DIM+1) bits, with no wrap beyond the terminal values.

Reset
REQ-027 SHALL, while rst is high, asynchronously force: state=LOAD; wr=rd=pass=0; all buf entries=0; out_valid=0, out_last=0, out_data=0, busy=0.
REQ-028 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL discard a partial frame when reset is asserted mid-LOAD, mid-SORT or mid-DRAIN; no element of that frame appears at the output afterward.

Structure
REQ-030 SHALL place the FSM state encoding (LOAD=0, SORT=1, DRAIN=2) and the default DIM/WIDTH constants in shared package bubble_pkg.
REQ-031 SHALL use one combinational sub-module, cmp_swap (two WIDTH inputs to ordered min/max outputs), instantiated floor(DIM/2) times and muxed per pass parity.
REQ-032 SHALL hold buf in flops, not RAM; no other sub-modules.

Verification
REQ-033 SHALL cover reverse order: DIM=4, input 4,3,2,1 -> output 1,2,3,4, out_last on element 4, first out_valid 5 cycles after last input.
REQ-034 SHALL cover duplicates and extremes: input 5,255,0,5 -> output 0,5,5,255.
REQ-035 SHALL cover backpressure: out_ready low 3 cycles during DRAIN of 7,1,9,3 -> out_data held at 1 while stalled, then 3,7,9 follow.
REQ-036 SHALL cover ignored input: in_valid=1 with data 0xAA throughout SORT/DRAIN of 2,1,2,1 -> in_ready=0 and output exactly 1,1,2,2.
REQ-037 SHALL cover reset mid-SORT: rst pulsed during pass 1 -> out_valid=0, in_ready=1 next cycle; next frame 3,0,2,1 -> output 0,1,2,3.
REQ-038 SHALL cover back-to-back frames: 100 random frames at DIM=5 and DIM=8, checked against a scoreboard sort with no gaps or lost elements.
